// File: rtl/lsu_arbiter.sv
// Round-robin arbiter that serialises load requests into a single-port LSU
// and holds each result until the CDB takes it; flush squashes the in-flight load.
module lsu_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ROB_TAG_W = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0][31:0]       req_rs1_val_i,
  input  logic [NUM_REQ-1:0][31:0]       req_imm_i,
  input  logic [NUM_REQ-1:0][5:0]        req_rd_p_i,
  input  logic [NUM_REQ-1:0][ROB_TAG_W-1:0] req_rob_tag_i,
  output logic [NUM_REQ-1:0]             req_ready_o,

  input  logic                           flush_i,

  output logic                           lsu_valid_o,
  output logic                           lsu_mem_read_o,
  output logic [31:0]                    lsu_rs1_val_o,
  output logic [31:0]                    lsu_imm_o,
  output logic [5:0]                     lsu_rd_p_o,
  output logic [ROB_TAG_W-1:0]           lsu_rob_tag_o,
  input  logic                           lsu_ready_i,

  input  logic                           lsu_valid_i,
  input  logic [31:0]                    lsu_result_i,
  input  logic [5:0]                     lsu_rd_p_i,
  input  logic [ROB_TAG_W-1:0]           lsu_rob_tag_i,

  output logic                           cdb_valid_o,
  output logic [31:0]                    cdb_result_o,
  output logic [5:0]                     cdb_rd_p_o,
  output logic [ROB_TAG_W-1:0]           cdb_rob_tag_o,
  input  logic                           cdb_ready_i
);

  localparam int                 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]     NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr;
  logic             squash;
  logic             grant_any;
  logic [PTR_W-1:0] winner;
  logic [PTR_W:0]   cand;
  logic             accept;

  assign lsu_mem_read_o = 1'b1;

  // Search upward from rr_ptr, wrapping modulo NUM_REQ, for the first valid requester.
  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_any && req_valid_i[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        winner    = cand[PTR_W-1:0];
      end
    end
  end

  assign accept = (state == IDLE) && !flush_i && grant_any;

  always_comb begin
    state_next  = state;
    req_ready_o = '0;
    lsu_valid_o = 1'b0;
    cdb_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready_o[winner] = 1'b1;
          state_next          = ISSUE;
        end
      end
      ISSUE: begin
        lsu_valid_o = !flush_i;
        if (flush_i)          state_next = IDLE;
        else if (lsu_ready_i) state_next = WAIT;
      end
      WAIT: begin
        if (lsu_valid_i) state_next = (squash || flush_i) ? IDLE : RESP;
      end
      RESP: begin
        cdb_valid_o = !flush_i;
        if (flush_i || cdb_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  // NOTE: payload and result registers are reset too, so every output is a defined 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      squash        <= 1'b0;
      lsu_rs1_val_o <= '0;
      lsu_imm_o     <= '0;
      lsu_rd_p_o    <= '0;
      lsu_rob_tag_o <= '0;
      cdb_result_o  <= '0;
      cdb_rd_p_o    <= '0;
      cdb_rob_tag_o <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        lsu_rs1_val_o <= req_rs1_val_i[winner];
        lsu_imm_o     <= req_imm_i[winner];
        lsu_rd_p_o    <= req_rd_p_i[winner];
        lsu_rob_tag_o <= req_rob_tag_i[winner];
        rr_ptr        <= (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);
      end
      if (state == WAIT) begin
        if (lsu_valid_i) begin
          squash <= 1'b0;
          if (!squash && !flush_i) begin
            cdb_result_o  <= lsu_result_i;
            cdb_rd_p_o    <= lsu_rd_p_i;
            cdb_rob_tag_o <= lsu_rob_tag_i;
          end
        end else if (flush_i) begin
          squash <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Randomised bench for lsu_arbiter: an emulated LSU plus a transaction-level
// model of the one-outstanding-load arbiter, checked every cycle.
module tb_lsu_arbiter;
  localparam int N  = 2;
  localparam int TW = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N-1:0]            req_valid_i = '0;
  logic [N-1:0][31:0]      req_rs1_val_i = '0;
  logic [N-1:0][31:0]      req_imm_i = '0;
  logic [N-1:0][5:0]       req_rd_p_i = '0;
  logic [N-1:0][TW-1:0]    req_rob_tag_i = '0;
  logic [N-1:0]            req_ready_o;
  logic                    flush_i = 1'b0;
  logic                    lsu_valid_o, lsu_mem_read_o;
  logic [31:0]             lsu_rs1_val_o, lsu_imm_o;
  logic [5:0]              lsu_rd_p_o;
  logic [TW-1:0]           lsu_rob_tag_o;
  logic                    lsu_ready_i = 1'b0;
  logic                    lsu_valid_i = 1'b0;
  logic [31:0]             lsu_result_i = '0;
  logic [5:0]              lsu_rd_p_i = '0;
  logic [TW-1:0]           lsu_rob_tag_i = '0;
  logic                    cdb_valid_o;
  logic [31:0]             cdb_result_o;
  logic [5:0]              cdb_rd_p_o;
  logic [TW-1:0]           cdb_rob_tag_o;
  logic                    cdb_ready_i = 1'b0;

  always #5 clk = ~clk;

  lsu_arbiter #(.NUM_REQ(N), .ROB_TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_rs1_val_i(req_rs1_val_i), .req_imm_i(req_imm_i),
    .req_rd_p_i(req_rd_p_i), .req_rob_tag_i(req_rob_tag_i), .req_ready_o(req_ready_o),
    .flush_i(flush_i),
    .lsu_valid_o(lsu_valid_o), .lsu_mem_read_o(lsu_mem_read_o),
    .lsu_rs1_val_o(lsu_rs1_val_o), .lsu_imm_o(lsu_imm_o),
    .lsu_rd_p_o(lsu_rd_p_o), .lsu_rob_tag_o(lsu_rob_tag_o), .lsu_ready_i(lsu_ready_i),
    .lsu_valid_i(lsu_valid_i), .lsu_result_i(lsu_result_i),
    .lsu_rd_p_i(lsu_rd_p_i), .lsu_rob_tag_i(lsu_rob_tag_i),
    .cdb_valid_o(cdb_valid_o), .cdb_result_o(cdb_result_o),
    .cdb_rd_p_o(cdb_rd_p_o), .cdb_rob_tag_o(cdb_rob_tag_o), .cdb_ready_i(cdb_ready_i)
  );

  typedef struct { logic [31:0] rs1; logic [31:0] imm; logic [5:0] rd; logic [TW-1:0] tag; } load_t;
  typedef struct { logic [31:0] data; logic [5:0] rd; logic [TW-1:0] tag; } res_t;
  typedef struct { int due; res_t r; } ret_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: at most one load owned; flags describe how far it has progressed.
  bit    m_busy, m_sent, m_have, m_doomed;
  int    m_pri;
  load_t m_cur;
  res_t  m_res;
  ret_t  lsu_q[$];
  int    grant_log[$];

  bit stray_en = 1'b0;
  bit rand_pay = 1'b1;
  bit lat_rand = 1'b0;
  int seen_accept = -1;
  int seen_cdb = -1;
  logic [TW-1:0] seen_tag = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic res_t lsu_model(input load_t l);
    res_t r;
    r.data = (l.rs1 + l.imm) ^ 32'h5A5A_0F0F;
    r.rd   = l.rd;
    r.tag  = l.tag;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sent = 0; m_have = 0; m_doomed = 0; m_pri = 0;
    m_cur = '{default: '0};
    m_res = '{default: '0};
    lsu_q.delete();
  endtask

  task automatic cycle(input logic fl, input logic [N-1:0] rv, input logic lr, input logic cr);
    logic [N-1:0] exp_rdy;
    bit   waiting;
    int   w, idx, lat;
    ret_t t;
    @(negedge clk);
    flush_i = fl; req_valid_i = rv; lsu_ready_i = lr; cdb_ready_i = cr;
    if (rand_pay) begin
      for (int r = 0; r < N; r++) begin
        req_rs1_val_i[r] = $urandom;
        req_imm_i[r]     = $urandom;
        req_rd_p_i[r]    = 6'($urandom);
        req_rob_tag_i[r] = TW'($urandom);
      end
    end
    waiting = m_busy && m_sent && !m_have;
    lsu_valid_i   = 1'b0;
    lsu_result_i  = $urandom;
    lsu_rd_p_i    = 6'($urandom);
    lsu_rob_tag_i = TW'($urandom);
    if (lsu_q.size() > 0 && lsu_q[0].due == cyc) begin
      t = lsu_q.pop_front();
      lsu_valid_i = 1'b1; lsu_result_i = t.r.data; lsu_rd_p_i = t.r.rd; lsu_rob_tag_i = t.r.tag;
    end else if (stray_en && !waiting && $urandom_range(0, 19) == 0) begin
      lsu_valid_i = 1'b1;
    end
    #1;
    exp_rdy = '0;
    w = -1;
    if (!m_busy && !fl) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_pri + k) % N;
        if (w < 0 && rv[idx]) w = idx;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", req_ready_o, exp_rdy);
    check("lsu_valid", lsu_valid_o, m_busy && !m_sent && !fl);
    check("mem_read", lsu_mem_read_o, 1);
    check("cdb_valid", cdb_valid_o, m_have && !fl);
    if (m_busy && !m_sent) begin
      check("lsu_rs1", lsu_rs1_val_o, m_cur.rs1);
      check("lsu_imm", lsu_imm_o, m_cur.imm);
      check("lsu_rd", lsu_rd_p_o, m_cur.rd);
      check("lsu_tag", lsu_rob_tag_o, m_cur.tag);
    end
    if (m_have) begin
      check("cdb_result", cdb_result_o, m_res.data);
      check("cdb_rd", cdb_rd_p_o, m_res.rd);
      check("cdb_tag", cdb_rob_tag_o, m_res.tag);
    end
    for (int r = 0; r < N; r++) if (req_ready_o[r]) grant_log.push_back(r);
    if (req_ready_o != '0) seen_accept = cyc;
    if (cdb_valid_o) begin seen_cdb = cyc; seen_tag = cdb_rob_tag_o; end

    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_sent = 0; m_have = 0;
        m_cur = '{req_rs1_val_i[w], req_imm_i[w], req_rd_p_i[w], req_rob_tag_i[w]};
        m_pri = (w + 1) % N;
      end
    end else if (!m_sent) begin
      if (fl) m_busy = 0;
      else if (lr) begin
        m_sent = 1;
        lat = lat_rand ? int'($urandom_range(2, 4)) : 2;
        lsu_q.push_back('{cyc + lat, lsu_model(m_cur)});
      end
    end else if (!m_have) begin
      if (lsu_valid_i) begin
        if (m_doomed || fl) begin m_busy = 0; m_doomed = 0; end
        else begin m_have = 1; m_res = '{lsu_result_i, lsu_rd_p_i, lsu_rob_tag_i}; end
      end else if (fl) m_doomed = 1;
    end else if (fl || cr) begin
      m_busy = 0; m_have = 0;
    end
    cyc++;
  endtask

  task automatic rand_cycle(input int pf, input int pr, input int pl, input int pc);
    logic [N-1:0] rv;
    logic fl, lr, cr;
    for (int r = 0; r < N; r++) rv[r] = (int'($urandom_range(0, 99)) < pr);
    fl = (int'($urandom_range(0, 99)) < pf);
    lr = (int'($urandom_range(0, 99)) < pl);
    cr = (int'($urandom_range(0, 99)) < pc);
    cycle(fl, rv, lr, cr);
  endtask

  task automatic drain();
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    int t0;
    bit reached;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_lsu_valid", lsu_valid_o, 0);
    check("rst_mem_read", lsu_mem_read_o, 1);
    check("rst_lsu_payload", {lsu_rs1_val_o, lsu_imm_o} | 64'(lsu_rd_p_o) | 64'(lsu_rob_tag_o), 0);
    check("rst_cdb_valid", cdb_valid_o, 0);
    check("rst_cdb_payload", 64'(cdb_result_o) | 64'(cdb_rd_p_o) | 64'(cdb_rob_tag_o), 0);
    rst_n = 1'b1;

    // Fairness from rr_ptr=0: both requesters held valid for four loads.
    grant_log.delete();
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) cycle(1'b0, 2'b11, 1'b1, 1'b1);
    check("fair_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) check("fair_grant", grant_log[i], i % 2);
    drain();

    // Single request with fixed payload: accept-to-CDB latency of 4.
    rand_pay = 1'b0;
    req_rs1_val_i[0] = 32'h100; req_imm_i[0] = 32'd4; req_rd_p_i[0] = 6'd9; req_rob_tag_i[0] = TW'(3);
    seen_cdb = -1;
    t0 = cyc;
    cycle(1'b0, 2'b01, 1'b1, 1'b1);
    check("single_accept", seen_accept, t0);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    check("single_latency", seen_cdb - t0, 4);
    check("single_tag", seen_tag, 3);
    rand_pay = 1'b1;
    drain();

    // CDB backpressure: three low cycles in RESP delay the next accept to cycle 8.
    t0 = cyc;
    for (int i = 0; i < 12; i++) cycle(1'b0, 2'b11, 1'b1, (i >= 7));
    check("bp_reaccept", seen_accept - t0, 8);
    drain();

    // Flush in WAIT at cycle 2: result discarded, next accept at cycle 4.
    t0 = cyc;
    seen_cdb = -1;
    for (int i = 0; i < 5; i++) cycle((i == 2), 2'b01, 1'b1, 1'b1);
    check("flush_wait_reaccept", seen_accept - t0, 4);
    check("flush_wait_no_cdb", seen_cdb, -1);
    drain();

    // Flush in IDLE, then in ISSUE; grant follows the first flush-free cycle.
    t0 = cyc;
    cycle(1'b1, 2'b01, 1'b1, 1'b1);
    cycle(1'b0, 2'b01, 1'b1, 1'b1);
    cycle(1'b1, 2'b01, 1'b1, 1'b1);
    cycle(1'b0, 2'b01, 1'b1, 1'b1);
    check("flush_issue_regrant", seen_accept - t0, 3);
    drain();

    stray_en = 1'b1;
    lat_rand = 1'b1;
    repeat (1200) rand_cycle(8, 50, 70, 60);
    repeat (800)  rand_cycle(25, 80, 50, 30);
    repeat (800)  rand_cycle(2, 90, 95, 95);

    // Async reset while the result is being offered on the CDB.
    stray_en = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      cycle(1'b0, 2'b11, 1'b1, 1'b0);
      reached = m_have;
    end
    check("resp_reached", reached, 1);
    @(negedge clk);
    flush_i = 1'b0; cdb_ready_i = 1'b0; lsu_valid_i = 1'b0;
    #2;
    check("pre_reset_cdb_valid", cdb_valid_o, reached);
    req_valid_i = '0;
    rst_n = 1'b0;
    #1;
    check("async_cdb_valid", cdb_valid_o, 0);
    check("async_cdb_result", cdb_result_o, 0);
    check("async_lsu_valid", lsu_valid_o, 0);
    check("async_req_ready", req_ready_o, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    stray_en = 1'b1;
    repeat (200) rand_cycle(8, 50, 70, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
